cpu_checkpoint_monitor: RTL and testbench
=========================================

CPU_CHECKPOINT_MONITOR -- requirements
Module: cpu_checkpoint_monitor

Interface
REQ-001 Parameter ADDR_W, default 16: width of IM and DM word addresses.
REQ-002 Parameter DATA_W, default 32: DM and golden data width.
REQ-003 Parameter NUM_CP, default 4: number of checkpoint table entries.
REQ-004 Parameter SETTLE, default 4: cycles waited after a checkpoint PC match before comparing.
REQ-005 Parameter TIMEOUT, default 1000: watchdog limit in cycles, used only with MON_WATCHDOG_EN.
REQ-006 clk  in  1  sole clock; all logic updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that arms the monitor at checkpoint 0.
REQ-009 cp_count  in  $clog2(NUM_CP+1)  number of active checkpoints.
REQ-010 cfg_we, cfg_idx, cfg_pc, cfg_lo, cfg_hi  in  1/$clog2(NUM_CP)/ADDR_W/ADDR_W/ADDR_W  checkpoint table write port.
REQ-011 IM_Address  in  ADDR_W  CPU fetch address being monitored.
REQ-012 dbg_addr  out  ADDR_W  address driven to both the DM debug read port and the golden read port.
REQ-013 dm_data, golden_data  in  DATA_W  read data, valid exactly 1 cycle after dbg_addr.
REQ-014 busy, done, pass, fail, timeout  out  1  status flags.
REQ-015 fail_cp  out  $clog2(NUM_CP)  index of the checkpoint with the first mismatch.
REQ-016 fail_addr  out  ADDR_W  address of the first mismatch.
REQ-017 err_count  out  8  mismatch count, saturating at 255.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_PC, SETTLE, CMP, DONE, FAIL.
REQ-019 IDLE: a cfg_we write SHALL update the table entry; start -> WAIT_PC with cur=0, or -> DONE if cp_count==0.
REQ-020 cfg_we outside IDLE SHALL be ignored.
REQ-021 WAIT_PC: IM_Address==cp[cur].pc -> SETTLE; only entry cur is matched, so checkpoints complete strictly in order.
REQ-022 SETTLE: exactly SETTLE cycles SHALL elapse, then -> CMP with dbg_addr=cp[cur].lo.
REQ-023 CMP: dbg_addr SHALL advance by 1 each cycle through cp[cur].hi; each word SHALL be compared one cycle after its address is issued; a range of n words SHALL take n+1 cycles.
REQ-024 Ranges with lo>hi SHALL compare zero words and pass after 1 cycle.
REQ-025 Mismatch: err_count SHALL increment; fail_cp and fail_addr SHALL latch only the first mismatch; comparison SHALL continue to the end of the range.
REQ-026 Range end: with any mismatch -> FAIL; otherwise cur+1 -> WAIT_PC, or -> DONE if cur+1==cp_count.
REQ-027 DONE SHALL assert done=1 and pass=1; FAIL SHALL assert done=1 and fail=1; both are terminal until start or rst.
REQ-028 start in DONE or FAIL SHALL clear status and counters and re-arm; start in any other state SHALL be ignored.
REQ-029 busy SHALL be 1 in WAIT_PC, SETTLE and CMP.

Reset
REQ-030 rst SHALL force IDLE, even mid-operation.
REQ-031 rst SHALL clear all outputs, dbg_addr, cur and the counters to 0.
REQ-032 rst SHALL clear the checkpoint table to all-zero entries.

Configuration
REQ-033 With MON_WATCHDOG_EN defined, a cycle counter SHALL run while busy and clear on each checkpoint match.
REQ-034 When that counter reaches TIMEOUT, the FSM SHALL go to FAIL with timeout=1 and fail_cp=cur.
REQ-035 Without MON_WATCHDOG_EN, no counter SHALL exist and timeout SHALL be tied to 0.

Structure
REQ-036 Package cpu_mon_pkg SHALL hold the FSM state enum, the checkpoint struct {pc, lo, hi}, and the ERR_MAX=255 constant.
REQ-037 Sub-module mon_cp_table SHALL hold the register-array checkpoint table and its write port.

Verification
REQ-038 cp0={pc 31, lo 0, hi 9}, DM equal to golden, IM_Address reaches 31 -> compare starts 4 cycles later; done=1, pass=1 after 11 compare cycles.
REQ-039 Golden[3]!=DM[3] and golden[7]!=DM[7] -> fail=1, fail_addr=3, fail_cp=0, err_count=2.
REQ-040 cp_count=2 with cp1.pc=42 reached before 31 -> no action until 31 passes; then cp1 is compared and pass=1.
REQ-041 MON_WATCHDOG_EN with TIMEOUT=1000 and IM_Address never reaching the pc -> timeout=1, fail=1 at cycle 1000.
REQ-042 rst asserted in CMP -> next cycle IDLE with all outputs 0; cfg_we during CMP leaves the table unchanged.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// Shared types for the CPU checkpoint monitor: FSM states, checkpoint entry, error counter limit.
// Checkpoint fields are CP_ADDR_W wide; the monitor's ADDR_W must not exceed it.
package cpu_mon_pkg;

    localparam int unsigned CP_ADDR_W = 16;
    localparam int unsigned ERR_W     = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_PC = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CMP     = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } mon_state_e;

    typedef struct packed {
        logic [CP_ADDR_W-1:0] pc;
        logic [CP_ADDR_W-1:0] lo;
        logic [CP_ADDR_W-1:0] hi;
    } cp_entry_t;

    // Saturating increment for the mismatch counter.
    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/mon_cp_table.sv
// Register-array checkpoint table with one write port and one combinational read port.
module mon_cp_table
    import cpu_mon_pkg::*;
#(
    parameter int unsigned NUM_CP = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_pc,
    input  logic [ADDR_W-1:0] wr_lo,
    input  logic [ADDR_W-1:0] wr_hi,
    input  logic [IDX_W-1:0]  rd_idx,
    output cp_entry_t         rd_entry_c
);

    cp_entry_t cp_q [NUM_CP];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CP); i++) begin
                cp_q[i] <= '0;
            end
        end else if (we) begin
            cp_q[wr_idx] <= cp_entry_t'{pc: CP_ADDR_W'(wr_pc),
                                        lo: CP_ADDR_W'(wr_lo),
                                        hi: CP_ADDR_W'(wr_hi)};
        end
    end

    assign rd_entry_c = cp_q[rd_idx];

endmodule

// File: rtl/cpu_checkpoint_monitor.sv
// Waits for the CPU to fetch each checkpoint PC in order, then compares a DM range against golden data.
// Optional build macro MON_WATCHDOG_EN adds a busy-cycle watchdog that forces FAIL with timeout=1.
module cpu_checkpoint_monitor
    import cpu_mon_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_CP  = 4,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(NUM_CP+1)-1:0]  cp_count,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CP)-1:0]    cfg_idx,
    input  logic [ADDR_W-1:0]            cfg_pc,
    input  logic [ADDR_W-1:0]            cfg_lo,
    input  logic [ADDR_W-1:0]            cfg_hi,
    input  logic [ADDR_W-1:0]            IM_Address,
    output logic [ADDR_W-1:0]            dbg_addr,
    input  logic [DATA_W-1:0]            dm_data,
    input  logic [DATA_W-1:0]            golden_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [$clog2(NUM_CP)-1:0]    fail_cp,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [7:0]                   err_count
);

    localparam int unsigned IDX_W = $clog2(NUM_CP);
    localparam int unsigned CNT_W = $clog2(NUM_CP + 1);
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    mon_state_e          state_q, state_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                issue_q, issue_d;
    logic                data_v_q, data_v_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [IDX_W-1:0]    fail_cp_q, fail_cp_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic                have_err_q, have_err_d;
    logic                busy_q, done_q, pass_q, fail_q;

    cp_entry_t           entry_c;
    logic [ADDR_W-1:0]   lo_c, hi_c;
    logic                cp_match_c, mismatch_c, tbl_we_c, busy_st_c;

    // Table is writable only while idle.
    assign tbl_we_c = cfg_we && (state_q == ST_IDLE);

    mon_cp_table #(
        .NUM_CP (NUM_CP),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .we         (tbl_we_c),
        .wr_idx     (cfg_idx),
        .wr_pc      (cfg_pc),
        .wr_lo      (cfg_lo),
        .wr_hi      (cfg_hi),
        .rd_idx     (cur_q),
        .rd_entry_c (entry_c)
    );

    assign lo_c       = ADDR_W'(entry_c.lo);
    assign hi_c       = ADDR_W'(entry_c.hi);
    assign cp_match_c = (IM_Address == ADDR_W'(entry_c.pc));
    assign mismatch_c = data_v_q && (dm_data != golden_data);
    assign busy_st_c  = (state_q == ST_WAIT_PC) || (state_q == ST_SETTLE) || (state_q == ST_CMP);

`ifdef MON_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        settle_d    = settle_q;
        addr_d      = addr_q;
        issue_d     = issue_q;
        data_v_d    = 1'b0;
        data_addr_d = data_addr_q;
        err_d       = err_q;
        fail_cp_d   = fail_cp_q;
        fail_addr_d = fail_addr_q;
        have_err_d  = have_err_q;
`ifdef MON_WATCHDOG_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    cur_d       = '0;
                    err_d       = '0;
                    fail_cp_d   = '0;
                    fail_addr_d = '0;
                    have_err_d  = 1'b0;
                    issue_d     = 1'b0;
`ifdef MON_WATCHDOG_EN
                    wd_d        = '0;
                    timeout_d   = 1'b0;
`endif
                    state_d     = (cp_count == '0) ? ST_DONE : ST_WAIT_PC;
                end
            end
            ST_WAIT_PC: begin
                if (cp_match_c) begin
                    if (SETTLE == 0) begin
                        state_d = ST_CMP;
                        addr_d  = lo_c;
                        issue_d = (lo_c <= hi_c);
                    end else begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == SET_W'(SETTLE - 1)) begin
                    state_d = ST_CMP;
                    addr_d  = lo_c;
                    issue_d = (lo_c <= hi_c);
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_CMP: begin
                // Data arriving now belongs to the address issued last cycle.
                if (mismatch_c) begin
                    err_d = err_sat_inc(err_q);
                    if (!have_err_q) begin
                        have_err_d  = 1'b1;
                        fail_cp_d   = cur_q;
                        fail_addr_d = data_addr_q;
                    end
                end
                if (issue_q) begin
                    data_v_d    = 1'b1;
                    data_addr_d = addr_q;
                    if (addr_q == hi_c) begin
                        issue_d = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (have_err_q || mismatch_c) begin
                    state_d = ST_FAIL;
                end else if ((CNT_W'(cur_q) + CNT_W'(1)) == cp_count) begin
                    state_d = ST_DONE;
                end else begin
                    cur_d   = cur_q + IDX_W'(1);
                    state_d = ST_WAIT_PC;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef MON_WATCHDOG_EN
        // Watchdog counts busy cycles since the last checkpoint match.
        if (busy_st_c) begin
            if ((state_q == ST_WAIT_PC) && cp_match_c) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                wd_d      = '0;
                state_d   = ST_FAIL;
                timeout_d = 1'b1;
                fail_cp_d = cur_q;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            settle_q    <= '0;
            addr_q      <= '0;
            issue_q     <= 1'b0;
            data_v_q    <= 1'b0;
            data_addr_q <= '0;
            err_q       <= '0;
            fail_cp_q   <= '0;
            fail_addr_q <= '0;
            have_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
`ifdef MON_WATCHDOG_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            settle_q    <= settle_d;
            addr_q      <= addr_d;
            issue_q     <= issue_d;
            data_v_q    <= data_v_d;
            data_addr_q <= data_addr_d;
            err_q       <= err_d;
            fail_cp_q   <= fail_cp_d;
            fail_addr_q <= fail_addr_d;
            have_err_q  <= have_err_d;
            busy_q      <= (state_d == ST_WAIT_PC) || (state_d == ST_SETTLE) || (state_d == ST_CMP);
            done_q      <= (state_d == ST_DONE) || (state_d == ST_FAIL);
            pass_q      <= (state_d == ST_DONE);
            fail_q      <= (state_d == ST_FAIL);
`ifdef MON_WATCHDOG_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign dbg_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_cp   = fail_cp_q;
    assign fail_addr = fail_addr_q;
    assign err_count = err_q;
`ifdef MON_WATCHDOG_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_checkpoint_monitor.sv
// Bench for cpu_checkpoint_monitor: table vectors, hand sequences and random runs against a range model.
module tb_cpu_checkpoint_monitor;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst, start, cfg_we;
    logic [2:0]  cp_count;
    logic [1:0]  cfg_idx, fail_cp;
    logic [15:0] cfg_pc, cfg_lo, cfg_hi, IM_Address, dbg_addr, fail_addr;
    logic [31:0] dm_data, golden_data;
    logic        busy, done, pass, fail, timeout;
    logic [7:0]  err_count;

    cpu_checkpoint_monitor dut (
        .clk(clk), .rst(rst), .start(start), .cp_count(cp_count),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .IM_Address(IM_Address), .dbg_addr(dbg_addr), .dm_data(dm_data), .golden_data(golden_data),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_cp(fail_cp), .fail_addr(fail_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    logic [31:0] dm_mem   [512];
    logic [31:0] gold_mem [512];

    // Both read ports return data one cycle after the address.
    always @(posedge clk) begin
        dm_data     <= dm_mem[dbg_addr[8:0]];
        golden_data <= gold_mem[dbg_addr[8:0]];
    end

    int checks = 0;
    int failures = 0;
    int ncp;
    int cp_pc [4];
    int cp_lo [4];
    int cp_hi [4];

    typedef struct {
        int ncp;
        int pc0, lo0, hi0, pc1, lo1, hi1;
        int bad0, bad1;
        bit exp_pass;
        int exp_err, exp_cp, exp_addr;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] filler();
        return 16'hF000 | 16'($urandom_range(0, 255));
    endfunction

    function automatic int nwords(input int k);
        return (cp_hi[k] >= cp_lo[k]) ? cp_hi[k] - cp_lo[k] + 1 : 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_pc = '0; cfg_lo = '0; cfg_hi = '0; cp_count = '0;
        IM_Address = filler();
        for (int k = 0; k < 4; k++) begin
            cp_pc[k] = 0; cp_lo[k] = 0; cp_hi[k] = 0;
        end
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 512; i++) begin
            dm_mem[i]   = $urandom;
            gold_mem[i] = dm_mem[i];
        end
    endtask

    task automatic cfg(input int idx, input int pc, input int lo, input int hi);
        cfg_we = 1'b1; cfg_idx = 2'(idx);
        cfg_pc = 16'(pc); cfg_lo = 16'(lo); cfg_hi = 16'(hi);
        tick();
        cfg_we = 1'b0;
        cp_pc[idx] = pc; cp_lo[idx] = lo; cp_hi[idx] = hi;
    endtask

    // Walks the configured ranges in order and stops at the first range holding a mismatch.
    task automatic predict(output bit ok, output int err, output int fcp, output int faddr);
        ok = 1'b1; err = 0; fcp = 0; faddr = 0;
        for (int k = 0; k < ncp; k++) begin
            bit bad = 1'b0;
            for (int a = cp_lo[k]; a <= cp_hi[k]; a++) begin
                if (dm_mem[9'(a)] != gold_mem[9'(a)]) begin
                    if (!bad) begin fcp = k; faddr = a; end
                    bad = 1'b1;
                    if (err < 255) err++;
                end
            end
            if (bad) begin ok = 1'b0; break; end
        end
    endtask

    // Presents each checkpoint PC for one cycle and expects the range to finish after SETTLE+n+1 cycles.
    task automatic run_cps(input string tag, input bit do_start, input bit exp_pass,
                           input int exp_err, input int exp_cp, input int exp_addr);
        int last_k;
        last_k = exp_pass ? ncp - 1 : exp_cp;
        if (do_start) begin
            cp_count = 3'(ncp); start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int k = 0; k <= last_k; k++) begin
            IM_Address = 16'(cp_pc[k]);
            tick();
            IM_Address = filler();
            repeat (SETTLE + nwords(k)) tick();
            if (k == last_k) chk({tag, "_done_early"}, 32'(done), 32'd0);
            tick();
            if (k < last_k) chk({tag, "_busy_between"}, 32'(busy), 32'd1);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_fail"}, 32'(fail), 32'(!exp_pass));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_fail_cp"}, 32'(fail_cp), 32'(exp_pass ? 0 : exp_cp));
        chk({tag, "_fail_addr"}, 32'(fail_addr), 32'(exp_pass ? 0 : exp_addr));
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit ok;
        int err, fcp, faddr;

        vt[0] = '{1, 31, 0, 9,   0,  0,  0, -1, -1, 1'b1, 0, 0, 0};
        vt[1] = '{1, 31, 0, 9,   0,  0,  0,  3,  7, 1'b0, 2, 0, 3};
        vt[2] = '{2, 31, 0, 9,  42, 20, 25, -1, -1, 1'b1, 0, 0, 0};
        vt[3] = '{1,  5, 10, 2,  0,  0,  0, 10,  2, 1'b1, 0, 0, 0};
        vt[4] = '{2, 31, 0, 9,  42, 20, 25, 24, 22, 1'b0, 2, 1, 22};
        vt[5] = '{1,  7, 12, 12, 0,  0,  0, 12, -1, 1'b0, 1, 0, 12};
        vt[6] = '{0, 31, 0, 9,   0,  0,  0, -1, -1, 1'b1, 0, 0, 0};

        fill_mem();
        do_reset();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pass_fail", 32'({pass, fail, timeout}), 32'd0);
        chk("reset_dbg_addr", 32'(dbg_addr), 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            fill_mem();
            if (vt[v].bad0 >= 0) gold_mem[vt[v].bad0] ^= 32'h1;
            if (vt[v].bad1 >= 0) gold_mem[vt[v].bad1] ^= 32'h8000_0000;
            cfg(0, vt[v].pc0, vt[v].lo0, vt[v].hi0);
            cfg(1, vt[v].pc1, vt[v].lo1, vt[v].hi1);
            ncp = vt[v].ncp;
            if (ncp == 0) begin
                cp_count = '0; start = 1'b1;
                tick();
                start = 1'b0;
                chk("vec_zero_cp_done", 32'(done), 32'd1);
                chk("vec_zero_cp_pass", 32'(pass), 32'd1);
            end else begin
                run_cps($sformatf("vec%0d", v), 1'b1, vt[v].exp_pass,
                        vt[v].exp_err, vt[v].exp_cp, vt[v].exp_addr);
            end
        end

        // Compare latency: lo issued 4 cycles after the match, one address per cycle.
        do_reset(); fill_mem();
        cfg(0, 31, 0, 9); ncp = 1; cp_count = 3'd1;
        start = 1'b1; tick(); start = 1'b0;
        IM_Address = 16'd31; tick(); IM_Address = filler();
        repeat (4) tick();
        chk("lat_busy_cmp", 32'(busy), 32'd1);
        chk("lat_lo", 32'(dbg_addr), 32'd0);
        tick();
        chk("lat_step1", 32'(dbg_addr), 32'd1);
        repeat (8) tick();
        chk("lat_hi", 32'(dbg_addr), 32'd9);
        tick();
        chk("lat_not_done", 32'(done), 32'd0);
        tick();
        chk("lat_done", 32'(done), 32'd1);
        chk("lat_pass", 32'(pass), 32'd1);

        // Later checkpoint PC seen early is ignored.
        do_reset(); fill_mem();
        cfg(0, 31, 0, 9); cfg(1, 42, 20, 25); ncp = 2; cp_count = 3'd2;
        start = 1'b1; tick(); start = 1'b0;
        IM_Address = 16'd42;
        repeat (5) tick();
        chk("order_still_waiting", 32'(busy), 32'd1);
        chk("order_no_compare", 32'(dbg_addr), 32'd0);
        run_cps("order", 1'b0, 1'b1, 0, 0, 0);

        // Restart from FAIL clears counters.
        do_reset(); fill_mem();
        gold_mem[3] ^= 32'h10;
        cfg(0, 31, 0, 9); ncp = 1;
        run_cps("rearm_a", 1'b1, 1'b0, 1, 0, 3);
        gold_mem[3] = dm_mem[3];
        run_cps("rearm_b", 1'b1, 1'b1, 0, 0, 0);

        // Table writes during CMP are dropped.
        do_reset(); fill_mem();
        cfg(0, 31, 0, 9); ncp = 1; cp_count = 3'd1;
        start = 1'b1; tick(); start = 1'b0;
        IM_Address = 16'd31; tick(); IM_Address = filler();
        repeat (6) tick();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_pc = 16'd50; cfg_lo = 16'd0; cfg_hi = 16'd0;
        tick();
        cfg_we = 1'b0;
        repeat (8) tick();
        chk("cfg_ignored_done", 32'(done), 32'd1);
        run_cps("cfg_ignored", 1'b1, 1'b1, 0, 0, 0);

        // Reset in CMP returns to idle and clears the table.
        do_reset(); fill_mem();
        cfg(0, 31, 0, 9); ncp = 1; cp_count = 3'd1;
        start = 1'b1; tick(); start = 1'b0;
        IM_Address = 16'd31; tick(); IM_Address = filler();
        repeat (7) tick();
        chk("rst_mid_dbg_nonzero", 32'(dbg_addr != 16'd0), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_flags", 32'({busy, done, pass, fail, timeout}), 32'd0);
        chk("rst_mid_dbg_addr", 32'(dbg_addr), 32'd0);
        chk("rst_mid_err_fail", 32'({err_count, fail_cp, fail_addr}), 32'd0);
        cp_pc[0] = 0; cp_lo[0] = 0; cp_hi[0] = 0;
        run_cps("rst_table_clear", 1'b1, 1'b1, 0, 0, 0);

        // Error counter saturates at 255.
        do_reset(); fill_mem();
        for (int i = 0; i < 300; i++) gold_mem[i] = ~dm_mem[i];
        cfg(0, 3, 0, 299); ncp = 1;
        predict(ok, err, fcp, faddr);
        run_cps("saturate", 1'b1, ok, err, fcp, faddr);

        for (int it = 0; it < 25; it++) begin
            int nbad;
            do_reset(); fill_mem();
            ncp = $urandom_range(1, 4);
            for (int k = 0; k < ncp; k++) begin
                cfg(k, k * 100 + int'($urandom_range(0, 99)),
                    int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
            end
            nbad = $urandom_range(0, 3);
            for (int b = 0; b < nbad; b++) begin
                gold_mem[$urandom_range(0, 40)] ^= (32'h1 << $urandom_range(0, 31));
            end
            predict(ok, err, fcp, faddr);
            run_cps($sformatf("rand%0d", it), 1'b1, ok, err, fcp, faddr);
        end

`ifdef MON_WATCHDOG_EN
        do_reset(); fill_mem();
        cfg(0, 31, 0, 9); ncp = 1; cp_count = 3'd1;
        start = 1'b1; tick(); start = 1'b0;
        IM_Address = filler();
        repeat (TIMEOUT - 1) tick();
        chk("wd_not_yet", 32'(fail), 32'd0);
        tick();
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_fail", 32'(fail), 32'd1);
        chk("wd_fail_cp", 32'(fail_cp), 32'd0);
`else
        chk("no_wd_timeout", 32'(timeout), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
